// File: rtl/vmask_reduce.sv
// Mask-register reduction for vcpop.m / vfirst.m over multi-beat mask vectors.
// Stage 1 reduces one beat; stage 2 accumulates across beats and registers the scalar result.
module vmask_reduce #(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned RESP_DATA_WIDTH = 64,
  parameter int unsigned CNT_WIDTH       = 32,
  parameter int unsigned AB_WIDTH        = $clog2(DATA_WIDTH) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [DATA_WIDTH-1:0]      in_mask,
  input  logic [DATA_WIDTH-1:0]      in_vm_mask,
  input  logic [AB_WIDTH-1:0]        in_active_bits,
  input  logic                       in_first,
  input  logic                       in_last,
  input  logic                       in_mode,
  output logic                       out_valid,
  output logic [RESP_DATA_WIDTH-1:0] out_vec
);

  localparam int unsigned LSB_WIDTH = $clog2(DATA_WIDTH);

  typedef enum logic {
    MODE_CPOP  = 1'b0,
    MODE_FIRST = 1'b1
  } mode_e;

  // ---------------------------------------------------------------------------
  // Beat reduction (combinational, feeds stage 1)
  // ---------------------------------------------------------------------------
  logic [AB_WIDTH-1:0]   ab_clamped;
  logic [DATA_WIDTH-1:0] tail;
  logic [DATA_WIDTH-1:0] eff;
  logic [AB_WIDTH-1:0]   pop;
  logic [LSB_WIDTH-1:0]  lsb;
  logic                  hit;
  logic [CNT_WIDTH-1:0]  base_q;
  logic [CNT_WIDTH-1:0]  beat_base;

  always_comb begin
    ab_clamped = (in_active_bits > AB_WIDTH'(DATA_WIDTH)) ? AB_WIDTH'(DATA_WIDTH) : in_active_bits;
    tail = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      tail[i] = (i < 32'(ab_clamped));
    end
    eff = in_mask & in_vm_mask & tail;
  end

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      pop = pop + AB_WIDTH'(eff[i]);
    end
  end

  // Scan from the top so the last assignment wins with the lowest set index.
  always_comb begin
    lsb = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      if (eff[DATA_WIDTH-1-i]) lsb = LSB_WIDTH'(DATA_WIDTH - 1 - i);
    end
    hit = |eff;
  end

  assign beat_base = in_first ? '0 : base_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q <= '0;
    end else if (in_valid) begin
      base_q <= beat_base + CNT_WIDTH'(ab_clamped);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1 register
  // ---------------------------------------------------------------------------
  logic                 s1_valid;
  logic [AB_WIDTH-1:0]  s1_pop;
  logic [LSB_WIDTH-1:0] s1_lsb;
  logic                 s1_hit;
  logic [CNT_WIDTH-1:0] s1_base;
  logic                 s1_first;
  logic                 s1_last;
  mode_e                s1_mode;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_pop   <= '0;
      s1_lsb   <= '0;
      s1_hit   <= 1'b0;
      s1_base  <= '0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_mode  <= MODE_CPOP;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_pop   <= pop;
        s1_lsb   <= lsb;
        s1_hit   <= hit;
        s1_base  <= beat_base;
        s1_first <= in_first;
        s1_last  <= in_last;
        s1_mode  <= mode_e'(in_mode);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 accumulator and result register
  // ---------------------------------------------------------------------------
  logic [CNT_WIDTH-1:0]       acc_q, acc_n;
  logic                       found_q, found_n;
  logic [CNT_WIDTH-1:0]       idx_q, idx_n;
  mode_e                      mode_q, mode_n;
  logic [RESP_DATA_WIDTH-1:0] result;

  // A first beat overrides the held state, so a restarted op drops its partial result.
  always_comb begin
    acc_n   = acc_q;
    found_n = found_q;
    idx_n   = idx_q;
    mode_n  = mode_q;
    if (s1_first) begin
      acc_n   = '0;
      found_n = 1'b0;
      idx_n   = '0;
      mode_n  = s1_mode;
    end
    if (mode_n == MODE_CPOP) begin
      acc_n = acc_n + CNT_WIDTH'(s1_pop);
    end else if (!found_n && s1_hit) begin
      found_n = 1'b1;
      idx_n   = s1_base + CNT_WIDTH'(s1_lsb);
    end
    if (mode_n == MODE_CPOP) begin
      result = RESP_DATA_WIDTH'(acc_n);
    end else if (found_n) begin
      result = RESP_DATA_WIDTH'(idx_n);
    end else begin
      result = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      found_q   <= 1'b0;
      idx_q     <= '0;
      mode_q    <= MODE_CPOP;
      out_valid <= 1'b0;
      out_vec   <= '0;
    end else begin
      out_valid <= 1'b0;
      out_vec   <= '0;
      if (s1_valid) begin
        acc_q   <= acc_n;
        found_q <= found_n;
        idx_q   <= idx_n;
        mode_q  <= mode_n;
        if (s1_last) begin
          out_valid <= 1'b1;
          out_vec   <= result;
        end
      end
    end
  end

endmodule
